// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for load data,
// buffers early load data under writeback back-pressure.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 71,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [4:0]                 mem_dst_reg,
  output logic                       mem_load_pending
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_bus;
  logic                       r_data_ok;
  logic [31:0]                r_rdata;

  logic        w_res_from_mem;
  logic        w_gr_we;
  logic [4:0]  w_dest;
  logic [31:0] w_alu_result;
  logic [31:0] w_pc;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_ready_go;
  logic        w_allowin;
  logic        w_to_ws_valid;
  logic        w_leave;
  logic        w_buf_set;

  assign w_res_from_mem = r_bus[70];
  assign w_gr_we        = r_bus[69];
  assign w_dest         = r_bus[68:64];
  assign w_alu_result   = r_bus[63:32];
  assign w_pc           = r_bus[31:0];

  assign w_ready_go    = !w_res_from_mem
                         || data_sram_data_ok
                         || r_data_ok;
  assign w_allowin     = !r_ms_valid
                         || (w_ready_go && ws_allowin);
  assign w_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_leave       = w_to_ws_valid && ws_allowin;

  // Data may arrive while writeback stalls; it is a one-cycle pulse,
  // so it must be parked until the instruction can leave.
  assign w_buf_set = r_ms_valid && w_res_from_mem && !r_data_ok
                     && data_sram_data_ok && !ws_allowin;

  assign w_load_data    = r_data_ok ? r_rdata : data_sram_rdata;
  assign w_final_result = w_res_from_mem ? w_load_data
                                         : w_alu_result;

  assign ms_allowin       = w_allowin;
  assign ms_to_ws_valid   = w_to_ws_valid;
  assign ms_to_ws_bus     = {w_gr_we, w_dest, w_final_result, w_pc};
  assign mem_dst_reg      = r_ms_valid ? w_dest : 5'd0;
  assign mem_load_pending = r_ms_valid && w_res_from_mem
                            && !w_ready_go;

  // Stage occupancy follows the upstream valid whenever we accept.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (w_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Payload is captured only for a real incoming instruction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_bus <= '0;
    end else if (es_to_ms_valid && w_allowin) begin
      r_bus <= es_to_ms_bus;
    end
  end

  // Load-data buffer; leaving the stage wins over a new capture.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_data_ok <= 1'b0;
      r_rdata   <= 32'd0;
    end else if (w_leave) begin
      r_data_ok <= 1'b0;
    end else if (w_buf_set) begin
      r_data_ok <= 1'b1;
      r_rdata   <= data_sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed cycle-table bench for mem_stage plus hand sequences for
// reset-during-load and writeback back-pressure on a non-load.
module tb_mem_stage;

  logic        clk;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [70:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [4:0]  mem_dst_reg;
  logic        mem_load_pending;

  int total;
  int bad;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .mem_dst_reg       (mem_dst_reg),
    .mem_load_pending  (mem_load_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        ev;
    logic        ld;
    logic        we;
    logic [4:0]  d;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        wa;
    logic        dok;
    logic [31:0] rd;
    logic        x_alw;
    logic        x_ov;
    logic [69:0] x_bus;
    logic [4:0]  x_dst;
    logic        x_pend;
  } vec_t;

  vec_t tv[17];

  function automatic logic [69:0] ob(
    input logic we, input logic [4:0] d,
    input logic [31:0] res, input logic [31:0] pc);
    return {we, d, res, pc};
  endfunction

  function automatic vec_t mk(
    input logic ev, input logic ld, input logic we,
    input logic [4:0] d, input logic [31:0] alu,
    input logic [31:0] pc, input logic wa,
    input logic dok, input logic [31:0] rd,
    input logic x_alw, input logic x_ov,
    input logic [69:0] x_bus, input logic [4:0] x_dst,
    input logic x_pend);
    vec_t v;
    v.rn = 1'b1;  v.ev = ev;   v.ld = ld;   v.we = we;
    v.d = d;      v.alu = alu; v.pc = pc;   v.wa = wa;
    v.dok = dok;  v.rd = rd;
    v.x_alw = x_alw; v.x_ov = x_ov; v.x_bus = x_bus;
    v.x_dst = x_dst; v.x_pend = x_pend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [69:0] act,
                     input logic [69:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic alw,
                         input logic ov, input logic [69:0] bus,
                         input logic [4:0] dst, input logic pend);
    chk({tag, ".allowin"}, 70'(ms_allowin), 70'(alw));
    chk({tag, ".to_ws_valid"}, 70'(ms_to_ws_valid), 70'(ov));
    chk({tag, ".bus"}, ms_to_ws_bus, bus);
    chk({tag, ".dst_reg"}, 70'(mem_dst_reg), 70'(dst));
    chk({tag, ".load_pending"}, 70'(mem_load_pending), 70'(pend));
  endtask

  task automatic drive(input logic rn, input logic ev, input logic ld,
                       input logic we, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] pc,
                       input logic wa, input logic dok,
                       input logic [31:0] rd);
    resetn            = rn;
    es_to_ms_valid    = ev;
    es_to_ms_bus      = {ld, we, d, alu, pc};
    ws_allowin        = wa;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // reset state
    tv[0]  = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                1,0,70'h0,5'd0,0);
    // non-load alu 0x12345678 dest 5
    tv[1]  = mk(1,0,1,5'd5,32'h1234_5678,32'hBFC0_0000,1,0,32'h0,
                1,0,70'h0,5'd0,0);
    tv[2]  = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                1,1,ob(1,5'd5,32'h1234_5678,32'hBFC0_0000),5'd5,0);
    // load dest 8, data 3 cycles after capture
    tv[3]  = mk(1,1,1,5'd8,32'h1111_1111,32'hBFC0_0010,1,0,32'h0,
                1,0,ob(1,5'd5,32'h1234_5678,32'hBFC0_0000),5'd0,0);
    tv[4]  = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                0,0,ob(1,5'd8,32'h0,32'hBFC0_0010),5'd8,1);
    tv[5]  = tv[4];
    tv[6]  = tv[4];
    tv[7]  = mk(0,0,0,5'd0,32'h0,32'h0,1,1,32'hDEAD_BEEF,
                1,1,ob(1,5'd8,32'hDEAD_BEEF,32'hBFC0_0010),5'd8,0);
    // load buffered under back-pressure; later data_ok ignored
    tv[8]  = mk(1,1,1,5'd9,32'h2222_2222,32'hBFC0_0020,1,0,32'h0,
                1,0,ob(1,5'd8,32'h0,32'hBFC0_0010),5'd0,0);
    tv[9]  = mk(0,0,0,5'd0,32'h0,32'h0,0,1,32'hCAFE_0001,
                0,1,ob(1,5'd9,32'hCAFE_0001,32'hBFC0_0020),5'd9,0);
    tv[10] = mk(0,0,0,5'd0,32'h0,32'h0,0,1,32'h7777_7777,
                0,1,ob(1,5'd9,32'hCAFE_0001,32'hBFC0_0020),5'd9,0);
    tv[11] = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                1,1,ob(1,5'd9,32'hCAFE_0001,32'hBFC0_0020),5'd9,0);
    // back-to-back non-loads
    tv[12] = mk(1,0,0,5'd3,32'hAAAA_0000,32'hBFC0_0000,1,0,32'h0,
                1,0,ob(1,5'd9,32'h0,32'hBFC0_0020),5'd0,0);
    tv[13] = mk(1,0,1,5'd4,32'hBBBB_0000,32'hBFC0_0004,1,0,32'h0,
                1,1,ob(0,5'd3,32'hAAAA_0000,32'hBFC0_0000),5'd3,0);
    tv[14] = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                1,1,ob(1,5'd4,32'hBBBB_0000,32'hBFC0_0004),5'd4,0);
    // spurious data_ok while empty
    tv[15] = mk(0,0,0,5'd0,32'h0,32'h0,1,1,32'h5555_5555,
                1,0,ob(1,5'd4,32'hBBBB_0000,32'hBFC0_0004),5'd0,0);
    tv[16] = mk(0,0,0,5'd0,32'h0,32'h0,1,0,32'h0,
                1,0,ob(1,5'd4,32'hBBBB_0000,32'hBFC0_0004),5'd0,0);

    drive(0,1,1,1,5'd31,32'hFFFF_FFFF,32'hFFFF_FFFF,1,1,32'hFFFF_FFFF);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tv[i].rn, tv[i].ev, tv[i].ld, tv[i].we, tv[i].d,
            tv[i].alu, tv[i].pc, tv[i].wa, tv[i].dok, tv[i].rd);
      #1;
      chk_all($sformatf("row%0d", i), tv[i].x_alw, tv[i].x_ov,
              tv[i].x_bus, tv[i].x_dst, tv[i].x_pend);
    end

    // reset while a load is pending, data_ok right after release
    @(negedge clk);
    drive(1,1,1,1,5'd7,32'h0,32'hBFC0_0030,1,0,32'h0);
    @(negedge clk);
    drive(1,0,0,0,5'd0,32'h0,32'h0,1,0,32'h0);
    #1;
    chk_all("rst_pend", 0, 0, ob(1,5'd7,32'h0,32'hBFC0_0030),
            5'd7, 1);
    @(negedge clk);
    drive(0,1,0,1,5'd12,32'hABCD_0000,32'hBFC0_0040,1,1,32'h0);
    @(negedge clk);
    drive(1,0,0,0,5'd0,32'h0,32'h0,0,1,32'h9999_9999);
    #1;
    chk_all("rst_after", 1, 0, 70'h0, 5'd0, 0);
    @(negedge clk);
    drive(1,0,0,0,5'd0,32'h0,32'h0,0,0,32'h0);
    #1;
    chk_all("rst_after2", 1, 0, 70'h0, 5'd0, 0);

    // non-load held by writeback back-pressure
    @(negedge clk);
    drive(1,1,0,1,5'd6,32'h1357_9BDF,32'hBFC0_0050,0,0,32'h0);
    @(negedge clk);
    drive(1,1,0,1,5'd10,32'h0,32'hBFC0_0054,0,0,32'h0);
    #1;
    chk_all("stall", 0, 1, ob(1,5'd6,32'h1357_9BDF,32'hBFC0_0050),
            5'd6, 0);
    @(negedge clk);
    drive(1,0,0,0,5'd0,32'h0,32'h0,1,0,32'h0);
    #1;
    chk_all("stall_rel", 1, 1,
            ob(1,5'd6,32'h1357_9BDF,32'hBFC0_0050), 5'd6, 0);
    @(negedge clk);
    #1;
    chk_all("stall_done", 1, 0,
            ob(1,5'd6,32'h1357_9BDF,32'hBFC0_0050), 5'd0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, default 71, shall set the width of the input bus from the execute stage.
REQ-002 Parameter MS_TO_WS_BUS_WD, default 70, shall set the width of the output bus to the writeback stage.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 resetn  input  1  synchronous, active-low reset.
REQ-005 ws_allowin  input  1  writeback stage can accept an instruction this cycle.
REQ-006 ms_allowin  output  1  this stage can accept an instruction from execute this cycle.
REQ-007 es_to_ms_valid  input  1  execute presents a valid instruction.
REQ-008 es_to_ms_bus  input  ES_TO_MS_BUS_WD  {res_from_mem[70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
REQ-009 ms_to_ws_valid  output  1  this stage presents a valid instruction to writeback.
REQ-010 ms_to_ws_bus  output  MS_TO_WS_BUS_WD  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 data_sram_data_ok  input  1  single-cycle pulse: load data for the outstanding request is on data_sram_rdata.
REQ-012 data_sram_rdata  input  32  load data, valid only while data_sram_data_ok=1.
REQ-013 mem_dst_reg  output  5  destination register of the held instruction, for decode hazard checks.
REQ-014 mem_load_pending  output  1  held instruction is a load whose data has not yet arrived.

Function
REQ-015 ms_valid shall load es_to_ms_valid on every edge where ms_allowin=1, and hold otherwise.
REQ-016 bus_r shall capture es_to_ms_bus on an edge where es_to_ms_valid=1 and ms_allowin=1, and hold otherwise.
REQ-017 ms_allowin shall equal !ms_valid || (ms_ready_go && ws_allowin).
REQ-018 ms_to_ws_valid shall equal ms_valid && ms_ready_go.
REQ-019 ms_ready_go shall be 1 for non-loads (res_from_mem=0), and for loads shall equal data_sram_data_ok || data_ok_r.
REQ-020 Data buffer: when ms_valid && res_from_mem && !data_ok_r && data_sram_data_ok && !ws_allowin, the stage shall set data_ok_r=1 and capture rdata_r=data_sram_rdata.
REQ-021 data_ok_r shall clear on the edge where ms_to_ws_valid && ws_allowin, and that clear shall take priority over a set in the same cycle.
REQ-022 data_sram_data_ok shall be ignored when ms_valid=0, res_from_mem=0, or data_ok_r=1; no state shall change.
REQ-023 final_result shall be data_ok_r ? rdata_r : data_sram_rdata for loads, and alu_result otherwise.
REQ-024 gr_we, dest and pc on ms_to_ws_bus shall pass through from bus_r unchanged.
REQ-025 mem_dst_reg shall equal ms_valid ? dest : 5'd0.
REQ-026 mem_load_pending shall equal ms_valid && res_from_mem && !ms_ready_go.
REQ-027 Latency: a non-load shall be offered to writeback the cycle after capture; a load shall be offered in the cycle data_ok arrives, or any later cycle once buffered.
REQ-028 Back-to-back: a new instruction shall be capturable on the same edge the current one leaves (ms_allowin=1 when ready_go && ws_allowin).

Reset
REQ-029 On an edge with resetn=0, ms_valid, data_ok_r, rdata_r and bus_r shall become 0, overriding any handshake in that cycle.
REQ-030 After reset: ms_allowin=1, ms_to_ws_valid=0, mem_dst_reg=0, mem_load_pending=0, ms_to_ws_bus=0.
REQ-031 Reset asserted mid-load shall discard the pending load; a data_ok in the first cycle after reset shall be ignored.

Verification
REQ-032 Non-load alu_result=0x1234_5678, dest=5, ws_allowin=1 -> ms_to_ws_valid=1 next cycle, final_result=0x1234_5678, mem_dst_reg=5.
REQ-033 Load dest=8, data_ok 3 cycles after capture with rdata=0xDEAD_BEEF -> mem_load_pending=1 and ms_allowin=0 for 3 cycles, then final_result=0xDEAD_BEEF with ms_to_ws_valid=1.
REQ-034 Load with data_ok=1, rdata=0xCAFE_0001, ws_allowin=0 for 2 cycles and rdata changed to 0 -> buffered; ms_to_ws_bus still shows 0xCAFE_0001 when ws_allowin=1.
REQ-035 Back-to-back non-loads pc=0xBFC0_0000 and 0xBFC0_0004 with ws_allowin=1 -> delivered on consecutive cycles with no bubble.
REQ-036 resetn=0 while a load is pending, then data_ok pulse right after release -> ms_valid=0, no output, data_ok_r=0.
REQ-037 Spurious data_ok while ms_valid=0 -> no state change, ms_to_ws_valid stays 0.
